sr_config_loader: RTL and testbench

SR_CONFIG_LOADER -- requirements
Module: sr_config_loader

---
 rtl/sr_config_loader_pkg.sv | 18 +
 rtl/sr_phase_timer.sv | 27 ++
 rtl/sr_config_loader.sv | 129 ++++++++++++
 tb/tb_sr_config_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_config_loader_pkg.sv
// Shared encodings for the serial divider configuration loader.
package sr_config_loader_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_NOP  = 2'b00;
    localparam sel_t SEL_DIV  = 2'b01;
    localparam sel_t SEL_ROW  = 2'b10;
    localparam sel_t SEL_BOTH = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_FINISH   = 3'd5;

endpackage

// File: rtl/sr_phase_timer.sv
// Phase timer: reloads on every phase entry and ticks on the last cycle of a
// SCLK_HALF-long phase.
module sr_phase_timer #(
    parameter int SCLK_HALF = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [7:0] RELOAD = 8'(SCLK_HALF - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= 8'd0;
        else if (i_load)
            r_cnt <= RELOAD;
        else if (r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;
    end

    assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/sr_config_loader.sv
// Serial loader for the divider's divisor and row-pixel shift registers,
// MSB first, with a programmable half-period shift clock and abort support.
module sr_config_loader
    import sr_config_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int SCLK_HALF  = 1
) (
    input  logic                  config_clock,
    input  logic                  external_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_sel,
    input  logic [WORD_WIDTH-1:0] cmd_divisor,
    input  logic [WORD_WIDTH-1:0] cmd_row_pixels,
    input  logic                  abort,
    output logic                  sr_data,
    output logic                  sr_data_clock,
    output logic                  sr_div_data_enable,
    output logic                  sr_row_data_enable,
    output logic                  divider_enable_n,
    output logic                  done,
    output logic                  aborted
);

    localparam int              BW       = $clog2(WORD_WIDTH) + 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(WORD_WIDTH - 1);

    logic [2:0]            r_state;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [WORD_WIDTH-1:0] r_row_word;
    logic [BW-1:0]         r_bits;
    logic                  r_cur_row;
    logic                  r_row_pend;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_aborted;

    logic [2:0] w_next_state;
    logic       w_tick;
    logic       w_accept;
    logic       w_abort;
    logic       w_in_word;

    assign w_accept = cmd_valid && r_ready;
    assign w_abort  = abort && (r_state != ST_IDLE);

    sr_phase_timer #(.SCLK_HALF(SCLK_HALF)) u_timer (
        .i_clk  (config_clock),
        .i_rst  (external_reset),
        .i_load (w_next_state != r_state),
        .o_tick (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next_state = (cmd_sel == SEL_NOP) ? ST_FINISH : ST_SETUP;
            ST_SETUP:    if (w_tick) w_next_state = ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_tick) w_next_state = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_tick) w_next_state = (r_bits == '0) ? ST_GAP : ST_SHIFT_HI;
            ST_GAP:      if (w_tick) w_next_state = r_row_pend ? ST_SETUP : ST_FINISH;
            ST_FINISH:   w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
        // Abort wins over every transition, including the FINISH exit.
        if (w_abort)
            w_next_state = ST_IDLE;
    end

    always_ff @(posedge config_clock or posedge external_reset) begin
        if (external_reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_row_word <= '0;
            r_bits     <= '0;
            r_cur_row  <= 1'b0;
            r_row_pend <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ready   <= (w_next_state == ST_IDLE);
            r_done    <= (r_state == ST_FINISH) && !w_abort;
            r_aborted <= w_abort;
            if (w_abort) begin
                r_shift    <= '0;
                r_bits     <= '0;
                r_cur_row  <= 1'b0;
                r_row_pend <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_accept) begin
                        r_shift    <= cmd_sel[0] ? cmd_divisor : cmd_row_pixels;
                        r_row_word <= cmd_row_pixels;
                        r_cur_row  <= (cmd_sel == SEL_ROW);
                        r_row_pend <= (cmd_sel == SEL_BOTH);
                        r_bits     <= LAST_BIT;
                    end
                    // Shifting on the HI->LO edge makes the next bit appear
                    // on the first low cycle.
                    ST_SHIFT_HI: if (w_tick) r_shift <= {r_shift[WORD_WIDTH-2:0], 1'b0};
                    ST_SHIFT_LO: if (w_tick && r_bits != '0) r_bits <= r_bits - BW'(1);
                    ST_GAP: if (w_tick && r_row_pend) begin
                        r_shift    <= r_row_word;
                        r_cur_row  <= 1'b1;
                        r_row_pend <= 1'b0;
                        r_bits     <= LAST_BIT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_in_word = (r_state == ST_SETUP) || (r_state == ST_SHIFT_HI) ||
                       (r_state == ST_SHIFT_LO);

    assign cmd_ready          = r_ready;
    assign sr_data            = w_in_word && r_shift[WORD_WIDTH-1];
    assign sr_data_clock      = (r_state == ST_SHIFT_HI);
    assign sr_div_data_enable = w_in_word && !r_cur_row;
    assign sr_row_data_enable = w_in_word && r_cur_row;
    assign divider_enable_n   = (r_state != ST_IDLE);
    assign done               = r_done;
    assign aborted            = r_aborted;

endmodule

// File: tb/tb_sr_config_loader.sv
// Randomized and directed bench for sr_config_loader; expected serial streams
// and timings are derived from the word list and half-period in a small model.
module tb_sr_config_loader;
    import sr_config_loader_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         abort = 1'b0;
    logic         use3 = 1'b0;
    logic [1:0]   cmd_sel = 2'b00;
    logic [W-1:0] cmd_div = '0;
    logic [W-1:0] cmd_row = '0;

    logic a_ready, a_data, a_sclk, a_den, a_ren, a_dn, a_done, a_ab;
    logic b_ready, b_data, b_sclk, b_den, b_ren, b_dn, b_done, b_ab;
    logic m_ready, m_data, m_sclk, m_den, m_ren, m_dn, m_done, m_ab;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_config_loader #(.WORD_WIDTH(W), .SCLK_HALF(1)) u_dut1 (
        .config_clock(clk), .external_reset(rst),
        .cmd_valid(cmd_valid & ~use3), .cmd_ready(a_ready), .cmd_sel(cmd_sel),
        .cmd_divisor(cmd_div), .cmd_row_pixels(cmd_row), .abort(abort & ~use3),
        .sr_data(a_data), .sr_data_clock(a_sclk), .sr_div_data_enable(a_den),
        .sr_row_data_enable(a_ren), .divider_enable_n(a_dn), .done(a_done), .aborted(a_ab)
    );

    sr_config_loader #(.WORD_WIDTH(W), .SCLK_HALF(3)) u_dut3 (
        .config_clock(clk), .external_reset(rst),
        .cmd_valid(cmd_valid & use3), .cmd_ready(b_ready), .cmd_sel(cmd_sel),
        .cmd_divisor(cmd_div), .cmd_row_pixels(cmd_row), .abort(abort & use3),
        .sr_data(b_data), .sr_data_clock(b_sclk), .sr_div_data_enable(b_den),
        .sr_row_data_enable(b_ren), .divider_enable_n(b_dn), .done(b_done), .aborted(b_ab)
    );

    assign {m_ready, m_data, m_sclk, m_den, m_ren, m_dn, m_done, m_ab} = use3 ?
        {b_ready, b_data, b_sclk, b_den, b_ren, b_dn, b_done, b_ab} :
        {a_ready, a_data, a_sclk, a_den, a_ren, a_dn, a_done, a_ab};

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [1:0] sel, input logic [W-1:0] d, input logic [W-1:0] r);
        int t = 0;
        cmd_sel = sel; cmd_div = d; cmd_row = r; cmd_valid = 1'b1;
        while (!m_ready && t < 500) begin @(negedge clk); t++; end
        chk("accept", longint'(m_ready), 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    // Watches one accepted request until its done/aborted pulse.
    task automatic observe(input logic [1:0] sel, input logic [W-1:0] div,
                           input logic [W-1:0] row, input int abort_at);
        bit [1:0] exp_q[$];
        bit [1:0] got_q[$];
        int h, nw, cyc, edges, div_cyc, row_cyc, both, bad_hi, bad_lo, chg_hi;
        int rdy_busy, dn_cyc, idle_busy, clk_idle, hirun, lorun, mism;
        logic p_clk, p_data, p_den, p_ren;
        bit fin;
        h = use3 ? 3 : 1;
        nw = int'(sel[0]) + int'(sel[1]);
        cyc = 0; edges = 0; div_cyc = 0; row_cyc = 0; both = 0; bad_hi = 0; bad_lo = 0;
        chg_hi = 0; rdy_busy = 0; dn_cyc = 0; idle_busy = 0; clk_idle = 0;
        hirun = 0; lorun = 0; mism = 0; fin = 0;
        p_clk = 0; p_data = 0; p_den = 0; p_ren = 0;
        if (sel[0]) for (int i = W-1; i >= 0; i--) exp_q.push_back({1'b0, div[i]});
        if (sel[1]) for (int i = W-1; i >= 0; i--) exp_q.push_back({1'b1, row[i]});
        if (abort_at > 0) while (exp_q.size() > abort_at) void'(exp_q.pop_back());
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            abort = 1'b0;
            if (m_done || m_ab) begin
                fin = 1;
                if (abort_at > 0) begin
                    chk("aborted_pulse", longint'(m_ab), 1);
                    chk("no_done_on_abort", longint'(m_done), 0);
                    chk("outs_low_after_abort", longint'({m_data, m_sclk, m_den, m_ren, m_dn}), 0);
                end else begin
                    chk("done_pulse", longint'(m_done), 1);
                    chk("no_aborted", longint'(m_ab), 0);
                    chk("den_n_low_at_done", longint'(m_dn), 0);
                    chk("ready_at_done", longint'(m_ready), 1);
                end
            end else begin
                if (m_ready) rdy_busy++;
                if (m_dn) dn_cyc++;
                if (m_den) div_cyc++;
                if (m_ren) row_cyc++;
                if (m_den && m_ren) both++;
                if (m_dn && !m_den && !m_ren) idle_busy++;
                if (m_dn && !m_den && !m_ren && m_sclk) clk_idle++;
                if (m_sclk && !p_clk) begin
                    edges++;
                    got_q.push_back({m_ren, m_data});
                    if (abort_at > 0 && edges == abort_at) abort = 1'b1;
                end
                if (m_sclk && p_clk && (m_data != p_data || m_den != p_den || m_ren != p_ren))
                    chg_hi++;
                if (m_sclk) hirun++;
                else if (hirun > 0) begin if (hirun != h) bad_hi++; hirun = 0; end
                if (!m_sclk && (m_den || m_ren)) lorun++;
                else if (lorun > 0) begin if (lorun != h) bad_lo++; lorun = 0; end
            end
            p_clk = m_sclk; p_data = m_data; p_den = m_den; p_ren = m_ren;
        end
        chk("txn_end_seen", longint'(fin), 1);
        chk("nbits", longint'(got_q.size()), longint'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) mism++;
        chk("bit_stream", mism, 0);
        chk("both_en_high", both, 0);
        chk("change_while_sclk_high", chg_hi, 0);
        chk("ready_while_busy", rdy_busy, 0);
        chk("sclk_high_outside_word", clk_idle, 0);
        if (abort_at == 0) begin
            chk("div_en_cycles", div_cyc, sel[0] ? (2*W+1)*h : 0);
            chk("row_en_cycles", row_cyc, sel[1] ? (2*W+1)*h : 0);
            chk("sclk_high_len", bad_hi, 0);
            chk("sclk_low_len", bad_lo, 0);
            chk("gap_finish_cycles", idle_busy, nw*h + 1);
            chk("den_n_cycles", dn_cyc, nw*(2*W+2)*h + 1);
        end
    endtask

    task automatic tail(input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (m_done || m_ab || m_dn || m_den || m_ren || m_sclk || m_data) bad++;
        end
        chk("quiet_after", bad, 0);
    endtask

    initial begin
        int t, bad, nw, ab;
        logic [1:0] s;
        logic [W-1:0] d, r;
        #1;
        chk("reset_outs_dut1", longint'({a_ready, a_data, a_sclk, a_den, a_ren, a_dn, a_done, a_ab}), 0);
        chk("reset_outs_dut3", longint'({b_ready, b_data, b_sclk, b_den, b_ren, b_dn, b_done, b_ab}), 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("ready_before_edge", longint'({a_ready, b_ready}), 0);
        @(posedge clk); #1;
        chk("ready_after_edge", longint'({a_ready, b_ready}), 3);
        @(negedge clk);

        // divisor only, H=1
        send(SEL_DIV, 32'd10, '0); observe(SEL_DIV, 32'd10, '0, 0); tail(3);
        // divisor then row
        send(SEL_BOTH, 32'd10, 32'd10); observe(SEL_BOTH, 32'd10, 32'd10, 0); tail(3);
        // row only, H=3
        use3 = 1'b1;
        send(SEL_ROW, '0, 32'h8000_0001); observe(SEL_ROW, '0, 32'h8000_0001, 0); tail(3);
        use3 = 1'b0;
        // no-op
        send(SEL_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF); observe(SEL_NOP, '0, '0, 0); tail(3);

        // valid held through a transfer: second command waits for IDLE
        cmd_sel = SEL_DIV; cmd_div = 32'd10; cmd_row = '0; cmd_valid = 1'b1;
        t = 0;
        while (!m_ready && t < 500) begin @(negedge clk); t++; end
        chk("chain_accept_a", longint'(m_ready), 1);
        @(posedge clk); #1 cmd_sel = SEL_ROW; cmd_row = 32'h1234_5678;
        observe(SEL_DIV, 32'd10, '0, 0);
        chk("chain_ready_b", longint'(m_ready), 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        observe(SEL_ROW, '0, 32'h1234_5678, 0); tail(4);

        // abort after the 10th rising edge, then a clean reload
        send(SEL_DIV, 32'd10, '0); observe(SEL_DIV, 32'd10, '0, 10); tail(3);
        send(SEL_DIV, 32'd10, '0); observe(SEL_DIV, 32'd10, '0, 0); tail(3);

        // reset mid-word
        send(SEL_DIV, 32'hA5A5_A5A5, '0);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1; #1;
        chk("midword_reset_outs", longint'({m_ready, m_data, m_sclk, m_den, m_ren, m_dn, m_done, m_ab}), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_done || m_ab || m_ready || m_dn || m_den || m_sclk) bad++;
        end
        chk("held_reset_quiet", bad, 0);
        rst = 1'b0; #1;
        chk("ready_low_at_release", longint'(m_ready), 0);
        @(posedge clk); #1;
        chk("ready_after_release", longint'(m_ready), 1);
        chk("no_pulse_after_reset", longint'({m_done, m_ab}), 0);
        @(negedge clk);
        send(SEL_DIV, 32'd10, '0); observe(SEL_DIV, 32'd10, '0, 0); tail(3);

        // randomized requests on both half-period variants
        for (int k = 0; k < 16; k++) begin
            use3 = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            d = $urandom;
            r = $urandom;
            nw = int'(s[0]) + int'(s[1]);
            ab = (nw > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, nw*W)) : 0;
            send(s, d, r);
            observe(s, d, r, ab);
            tail(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
